// File: rtl/serial_add_seq.sv
// Bit-serial sequencer around an external 1-bit full adder: shifts operands out
// LSB-first, feeds the carry back, and collects the serial sum into sum/cout.
module serial_add_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_s,
  input  logic             fa_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CNT_W-1:0] count;
  logic             last;

  assign last = (count == CNT_W'(WIDTH - 1));

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
        else       state_next = IDLE;
      end
      RUN: begin
        if (last) state_next = DONE;
        else      state_next = RUN;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Operand shifters, carry feedback, bit counter and result accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      sum     <= '0;
      cout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            count   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
          end
        end
        RUN: begin
          // Sum enters at the MSB so after WIDTH shifts bit 0 lands at sum[0]
          sum     <= {fa_s, sum[WIDTH-1:1]};
          a_sh    <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh    <= {1'b0, b_sh[WIDTH-1:1]};
          carry_q <= fa_cout;
          if (last) begin
            cout  <= fa_cout;
            count <= '0;
          end else begin
            count <= count + CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Adder drive is gated by the registered state so idle values never leak out
  assign fa_a   = (state == RUN) & a_sh[0];
  assign fa_b   = (state == RUN) & b_sh[0];
  assign fa_cin = (state == RUN) & carry_q;
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed and randomized bench for serial_add_seq with a behavioural full adder.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       busy, done, cout, fa_a, fa_b, fa_cin, fa_s, fa_cout;
  logic [7:0] sum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign fa_s    = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

  serial_add_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout),
    .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s), .fa_cout(fa_cout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one op from IDLE, scramble the inputs after acceptance, wait for done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                       output logic [8:0] res, output int lat);
    a = ia; b = ib; cin = ic; start = 1'b1;
    tick();
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res = {cout, sum};
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
    n_cmp++; if ({cout, sum} !== 9'h000) begin n_err++; $display("FAIL reset_sum got %h exp 000", {cout, sum}); end
    n_cmp++; if ({fa_a, fa_b, fa_cin} !== 3'b000) begin n_err++; $display("FAIL reset_fa got %b exp 000", {fa_a, fa_b, fa_cin}); end
    rst = 1'b0; start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_no_start cyc %0d busy %b exp 0", i, busy); end
    end
  endtask

  task automatic test_basic();
    logic [7:0] tr_a, tr_b, tr_c;
    int busy_cyc;
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; a = 8'hF0; b = 8'hF0; cin = 1'b1;
    busy_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      tr_a[i] = fa_a; tr_b[i] = fa_b; tr_c[i] = fa_cin;
      if (busy === 1'b1) busy_cyc++;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL basic_early_done bit %0d got %b exp 0", i, done); end
      tick();
    end
    if (busy === 1'b1) busy_cyc++;
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL basic_done_latency got %b exp 1", done); end
    n_cmp++; if (tr_a !== 8'h0F) begin n_err++; $display("FAIL basic_fa_a_trace got %h exp 0f", tr_a); end
    n_cmp++; if (tr_b !== 8'h01) begin n_err++; $display("FAIL basic_fa_b_trace got %h exp 01", tr_b); end
    n_cmp++; if (tr_c !== 8'h1E) begin n_err++; $display("FAIL basic_fa_cin_trace got %h exp 1e", tr_c); end
    n_cmp++; if ({cout, sum} !== 9'h010) begin n_err++; $display("FAIL basic_result got %h exp 010", {cout, sum}); end
    n_cmp++; if ({fa_a, fa_b, fa_cin} !== 3'b000) begin n_err++; $display("FAIL basic_fa_in_done got %b exp 000", {fa_a, fa_b, fa_cin}); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL basic_after_done got %b exp 00", {busy, done}); end
    n_cmp++; if (busy_cyc !== 9) begin n_err++; $display("FAIL basic_busy_cycles got %0d exp 9", busy_cyc); end
  endtask

  task automatic test_carry_chain();
    logic [8:0] res;
    int lat;
    do_op(8'hFF, 8'h01, 1'b0, res, lat);
    n_cmp++; if (res !== 9'h100) begin n_err++; $display("FAIL carry_ff_01 got %h exp 100", res); end
    n_cmp++; if (lat !== 9) begin n_err++; $display("FAIL carry_ff_01_lat got %0d exp 9", lat); end
    do_op(8'hFF, 8'hFF, 1'b1, res, lat);
    n_cmp++; if (res !== 9'h1FF) begin n_err++; $display("FAIL carry_ff_ff_1 got %h exp 1ff", res); end
    do_op(8'h00, 8'h00, 1'b1, res, lat);
    n_cmp++; if (res !== 9'h001) begin n_err++; $display("FAIL carry_cin_only got %h exp 001", res); end
  endtask

  task automatic test_busy_protect();
    int guard;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (done !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL busy_done_timeout got %b exp 1", done); end
    n_cmp++; if ({cout, sum} !== 9'h046) begin n_err++; $display("FAIL busy_result got %h exp 046", {cout, sum}); end
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    tick();
    start = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_start_in_done got %b exp 0", busy); end
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_no_queue got %b exp 0", busy); end
    n_cmp++; if ({cout, sum} !== 9'h046) begin n_err++; $display("FAIL busy_hold got %h exp 046", {cout, sum}); end
  endtask

  task automatic test_back_to_back();
    int gap;
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) tick();
    n_cmp++; if ({done, cout, sum} !== 10'h203) begin n_err++; $display("FAIL b2b_first got %h exp 203", {done, cout, sum}); end
    a = 8'h10; b = 8'h20;
    gap = 0;
    tick();
    gap++;
    while (done !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    start = 1'b0;
    n_cmp++; if (gap !== 10) begin n_err++; $display("FAIL b2b_period got %0d exp 10", gap); end
    n_cmp++; if ({cout, sum} !== 9'h030) begin n_err++; $display("FAIL b2b_second got %h exp 030", {cout, sum}); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [8:0] res;
    int lat;
    int seen_done;
    a = 8'h55; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL midrst_state got %b exp 00", {busy, done}); end
    n_cmp++; if ({cout, sum} !== 9'h000) begin n_err++; $display("FAIL midrst_sum got %h exp 000", {cout, sum}); end
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) seen_done++;
    end
    n_cmp++; if (seen_done !== 0) begin n_err++; $display("FAIL midrst_no_done got %0d exp 0", seen_done); end
    do_op(8'h03, 8'h05, 1'b0, res, lat);
    n_cmp++; if (res !== 9'h008) begin n_err++; $display("FAIL midrst_next_op got %h exp 008", res); end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb;
    logic       rc;
    logic [8:0] res, expv;
    int lat, bad, bad_lat, bad_hold;
    bad = 0; bad_lat = 0; bad_hold = 0;
    for (int n = 0; n < 500; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      expv = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
      do_op(ra, rb, rc, res, lat);
      if (res !== expv) begin
        bad++;
        if (bad < 5) $display("FAIL rand_result a=%h b=%h c=%b got %h exp %h", ra, rb, rc, res, expv);
      end
      if (lat !== 9) bad_lat++;
      for (int k = 0; k < int'($urandom_range(3, 0)); k++) begin
        a = 8'($urandom); b = 8'($urandom);
        tick();
        if ({cout, sum} !== expv || busy !== 1'b0) bad_hold++;
      end
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL rand_results got %0d bad exp 0", bad); end
    n_cmp++; if (bad_lat !== 0) begin n_err++; $display("FAIL rand_latency got %0d bad exp 0", bad_lat); end
    n_cmp++; if (bad_hold !== 0) begin n_err++; $display("FAIL rand_hold got %0d bad exp 0", bad_hold); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry_chain();
    test_busy_protect();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial sequencer that sits directly around the 1-bit full adder in tt_um_SUMADOR.
- Accepts two WIDTH-bit operands plus carry-in, and presents them LSB-first to the adder, one bit per clock (drives the adder's inputs, consumes its sum/carry).
- Carries the adder's carry-out to the next bit position and accumulates the serial sum into a WIDTH-bit result with carry-out.
- Reports completion with a one-cycle done pulse; the design package ties the 1-bit adder's ports to fa_*.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk, input, 1, single system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request; sampled only in IDLE.
- a, input, WIDTH, operand A; captured on the accepted start.
- b, input, WIDTH, operand B; captured on the accepted start.
- cin, input, 1, carry-in; captured on the accepted start.
- busy, output, 1, high in RUN and DONE.
- done, output, 1, one-cycle pulse: result valid.
- sum, output, WIDTH, result; holds until the next accepted start.
- cout, output, 1, final carry; holds with sum.
- fa_a, output, 1, bit to full-adder input A.
- fa_b, output, 1, bit to full-adder input B.
- fa_cin, output, 1, carry to full-adder carry-in.
- fa_s, input, 1, full-adder sum (combinational from fa_*).
- fa_cout, input, 1, full-adder carry-out.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state=IDLE.
  - a_sh, b_sh, sum, cout, carry_q, count = 0.
  - busy=0, done=0, fa_a/fa_b/fa_cin=0.
  - rst overrides start and all state activity in the same cycle.
- State machine: IDLE, RUN, DONE (one-hot or binary, implementer's choice).
- IDLE:
  - start=1 at an edge: a_sh<=a, b_sh<=b, carry_q<=cin, count<=0, sum<=0, cout<=0, state<=RUN.
  - start=0: hold; sum and cout keep their last result.
- RUN (exactly WIDTH cycles):
  - fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=carry_q, all driven straight from registers.
  - Each edge: sum<={fa_s, sum[WIDTH-1:1]}; a_sh>>=1; b_sh>>=1; carry_q<=fa_cout; count<=count+1.
  - When count==WIDTH-1 at an edge: final shift done, cout<=fa_cout, state<=DONE.
- DONE (one cycle): done=1, busy=1; next edge state<=IDLE.
- Outputs outside RUN:
  - fa_a/fa_b/fa_cin=0 in IDLE and DONE.
  - done=0 outside DONE.
  - busy=0 only in IDLE.
- Latency: start sampled at edge E0 -> RUN cycles E0..E0+WIDTH -> done high in the cycle after edge E0+WIDTH (WIDTH+1 edges after acceptance). Back-to-back throughput is one op per WIDTH+2 cycles.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1); no overflow flag.
- Boundary conditions:
  - start while busy is ignored; it is neither queued nor able to corrupt operands.
  - Changes on a/b/cin after acceptance have no effect.
  - start high in the DONE cycle is ignored; it is accepted only once back in IDLE.
  - rst mid-RUN or in DONE: abort; the next cycle is IDLE with zeroed outputs and no done pulse.
  - Wrap-around: count never exceeds WIDTH-1.
- No combinational path from start, a, b or cin to any output.

Test Plan:
- Reset: hold rst=1 for 2 cycles with start=1, a=8'hAA -> busy=0, done=0, sum=00, cout=0, fa_*=0; no operation starts after rst drops unless start is re-sampled.
- Basic add, with the bench modelling the full adder behaviourally:
  - Stimulus: a=8'h0F, b=8'h01, cin=0, start for 1 cycle.
  - Timing: busy=1 for 9 cycles; done pulses exactly 9 edges after acceptance.
  - Result: sum=8'h10, cout=0.
  - Serial trace: fa_a sequence 1,1,1,1,0,0,0,0.
- Carry chain:
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Busy protection:
  - Run a=8'h12, b=8'h34; pulse start with a=8'hFF during RUN cycle 3 and during DONE.
  - Required: result sum=8'h46, cout=0.
  - Required: a new op starts only on a start sampled in IDLE.
- Reset mid-op: assert rst during RUN cycle 4 of a=8'h55, b=8'h55 -> next cycle busy=0, sum=0, no done pulse; a following op a=8'h03, b=8'h05 yields sum=8'h08.
- Randomized regression: 500 random (a, b, cin) triples with random start spacing -> {cout,sum}==a+b+cin every time; sum/cout stable between done and the next accepted start.
